// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte per frame and serialises it as 8N1, LSB first.
// Optional even-parity bit when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [BW-1:0]     bit_reg, bit_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              tx_reg, tx_next;
  logic              rd_en_reg, rd_en_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_reg, parity_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
      rd_en_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      tx_reg     <= tx_next;
      rd_en_reg  <= rd_en_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: if (!fifo_empty) state_next = POP;
      POP:  state_next = LOAD;
      LOAD: begin
        shift_next = fifo_data;
        cnt_next   = '0;
        bit_next   = '0;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_next = ^fifo_data;
`endif
        state_next = START;
      end
      START: begin
        if (cnt_reg == CNT_MAX) begin
          cnt_next   = '0;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_MAX) begin
          cnt_next   = '0;
          shift_next = shift_reg >> 1;
          if (bit_reg == BIT_LAST) begin
            bit_next = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_reg == CNT_MAX) begin
          cnt_next   = '0;
          state_next = STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_reg == CNT_MAX) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up with state_reg.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:  tx_next = 1'b0;
      DATA:   tx_next = shift_next[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: tx_next = parity_next;
`endif
      default: tx_next = 1'b1;
    endcase
    rd_en_next = (state_next == POP);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == STOP) && (cnt_next == CNT_MAX);
  end

  assign tx         = tx_reg;
  assign fifo_rd_en = rd_en_reg;
  assign tx_busy    = busy_reg;
  assign tx_done    = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small registered-FIFO model on the read side.
// Build with FIFO_UART_TX_PARITY_EN defined to also exercise the parity bit.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int EXP_LEN    = 44;
`else
  localparam int FRAME_BITS = 10;
  localparam int EXP_LEN    = 40;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en, tx, tx_busy, tx_done;

  logic       model_empty = 1'b1;
  logic       ovr_en = 1'b0;
  logic       ovr_val = 1'b1;
  logic [7:0] q[$];
  int         rd_count = 0;
  int         underflow = 0;
  int         total = 0;
  int         bad = 0;

  assign fifo_empty = ovr_en ? ovr_val : model_empty;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  // Registered FIFO read side: data_out and empty update on the rd_en edge.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_count++;
      if (q.size() > 0) fifo_data <= q.pop_front();
      else underflow++;
    end
    model_empty <= (q.size() == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for a start bit and records one whole frame; does no checking itself.
  task automatic get_frame(output int gap, output logic [7:0] data, output logic par,
                           output int len, output int unstable, output int busy_low,
                           output logic stop_bit);
    logic [63:0] samp;
    int n;
    samp = '1; gap = 0; data = '0; par = 1'b0; len = -1;
    unstable = 0; busy_low = 0; stop_bit = 1'b0;
    @(negedge clk);
    while (tx !== 1'b0 && gap < 300) begin
      gap++;
      @(negedge clk);
    end
    if (tx !== 1'b0) return;
    n = 0;
    while (n < 64) begin
      samp[n] = tx;
      if (tx_busy !== 1'b1) busy_low++;
      n++;
      if (tx_done === 1'b1) break;
      @(negedge clk);
    end
    len = n;
    for (int k = 0; k < FRAME_BITS; k++)
      for (int j = 1; j < CPB; j++)
        if (samp[k*CPB+j] !== samp[k*CPB]) unstable++;
    for (int i = 0; i < 8; i++) data[i] = samp[(i+1)*CPB];
    par = samp[9*CPB];
    stop_bit = samp[len-1];
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
  endtask

  task automatic test_reset;
    int tx_low, busy_hi, done_hi, rd_hi;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
    rst_n = 1'b1;
    tx_low = 0; busy_hi = 0; done_hi = 0; rd_hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
      if (tx_busy !== 1'b0) busy_hi++;
      if (tx_done !== 1'b0) done_hi++;
      if (fifo_rd_en !== 1'b0) rd_hi++;
    end
    total++; if (tx_low != 0) begin bad++; $display("FAIL idle_tx: tx low %0d cycles want 0", tx_low); end
    total++; if (busy_hi != 0) begin bad++; $display("FAIL idle_busy: busy %0d cycles want 0", busy_hi); end
    total++; if (done_hi != 0) begin bad++; $display("FAIL idle_done: done %0d cycles want 0", done_hi); end
    total++; if (rd_hi != 0 || rd_count != 0) begin bad++; $display("FAIL idle_rd_en: rd_en %0d cycles want 0", rd_hi); end
    $display("test_reset: idle 50 cycles checked");
  endtask

  task automatic test_single_byte;
    int gap, len, unst, bl, rd0;
    logic [7:0] d;
    logic p, sb;
    rd0 = rd_count;
    push(8'hA5);
    get_frame(gap, d, p, len, unst, bl, sb);
    total++; if (d !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", d); end
    total++; if (len != EXP_LEN) begin bad++; $display("FAIL single_len: done at cycle %0d want %0d", len, EXP_LEN); end
    total++; if (unst != 0) begin bad++; $display("FAIL single_bit_hold: %0d unstable samples want 0", unst); end
    total++; if (bl != 0) begin bad++; $display("FAIL single_busy: busy low %0d cycles want 0", bl); end
    total++; if (sb !== 1'b1) begin bad++; $display("FAIL single_stop: got %b want 1", sb); end
    @(negedge clk);
    total++; if (tx_done !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL single_after: done=%b tx=%b want 0/1", tx_done, tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b want 0", tx_busy); end
    repeat (8) @(negedge clk);
    total++; if (rd_count - rd0 != 1) begin bad++; $display("FAIL single_pops: got %0d want 1", rd_count - rd0); end
    $display("test_single_byte: byte=%h len=%0d", d, len);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b [3];
    int gap, len, unst, bl, rd0;
    logic [7:0] d;
    logic p, sb;
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
    rd0 = rd_count;
    for (int i = 0; i < 3; i++) push(exp_b[i]);
    for (int i = 0; i < 3; i++) begin
      get_frame(gap, d, p, len, unst, bl, sb);
      total++; if (d !== exp_b[i]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, d, exp_b[i]); end
      total++; if (len != EXP_LEN || unst != 0) begin bad++; $display("FAIL b2b_frame%0d: len=%0d unstable=%0d want %0d/0", i, len, unst, EXP_LEN); end
      if (i > 0) begin
        total++; if (gap != 3) begin bad++; $display("FAIL b2b_gap%0d: got %0d want 3", i, gap); end
      end
      $display("test_back_to_back: frame %0d byte=%h gap=%0d", i, d, gap);
    end
    repeat (20) @(negedge clk);
    total++; if (rd_count - rd0 != 3) begin bad++; $display("FAIL b2b_pops: got %0d want 3", rd_count - rd0); end
  endtask

  task automatic test_reset_mid_frame;
    int gap, len, unst, bl, rd0, w, lows;
    logic [7:0] d;
    logic p, sb;
    rd0 = rd_count;
    push(8'h55);
    push(8'h66);
    w = 0;
    @(negedge clk);
    while (tx !== 1'b0 && w < 300) begin w++; @(negedge clk); end
    total++;
    if (tx !== 1'b0) begin
      bad++; $display("FAIL midrst_start: no start bit got tx=%b want 0", tx);
      return;
    end
    repeat (17) @(negedge clk);
    total++; if (tx !== 1'b0) begin bad++; $display("FAIL midrst_bit3: got %b want 0", tx); end
    rst_n = 1'b0;
    #1;
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL midrst_tx_async: got %b want 1", tx); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", tx_busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    get_frame(gap, d, p, len, unst, bl, sb);
    total++; if (d !== 8'h66) begin bad++; $display("FAIL midrst_next: got %h want 66", d); end
    total++; if (len != EXP_LEN) begin bad++; $display("FAIL midrst_len: got %0d want %0d", len, EXP_LEN); end
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    total++; if (lows != 0) begin bad++; $display("FAIL midrst_resend: tx low %0d cycles want 0", lows); end
    total++; if (rd_count - rd0 != 2) begin bad++; $display("FAIL midrst_pops: got %0d want 2", rd_count - rd0); end
    $display("test_reset_mid_frame: after reset byte=%h", d);
  endtask

  task automatic test_empty_toggle;
    int gap, len, unst, bl, rd0;
    logic [7:0] d;
    logic p, sb;
    rd0 = rd_count;
    push(8'h5A);
    fork
      get_frame(gap, d, p, len, unst, bl, sb);
      begin
        repeat (16) @(negedge clk);
        ovr_en = 1'b1; ovr_val = 1'b1;
        @(negedge clk);
        ovr_val = 1'b0;
        repeat (3) @(negedge clk);
        ovr_val = 1'b1;
        @(negedge clk);
        ovr_en = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    total++; if (d !== 8'h5A) begin bad++; $display("FAIL toggle_data: got %h want 5a", d); end
    total++; if (len != EXP_LEN || unst != 0) begin bad++; $display("FAIL toggle_timing: len=%0d unstable=%0d want %0d/0", len, unst, EXP_LEN); end
    total++; if (rd_count - rd0 != 1) begin bad++; $display("FAIL toggle_pops: got %0d want 1", rd_count - rd0); end
    total++; if (underflow != 0) begin bad++; $display("FAIL toggle_underflow: got %0d want 0", underflow); end
    $display("test_empty_toggle: byte=%h len=%0d", d, len);
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity;
    int gap, len, unst, bl;
    logic [7:0] d;
    logic p, sb;
    push(8'h07);
    get_frame(gap, d, p, len, unst, bl, sb);
    total++; if (p !== 1'b1) begin bad++; $display("FAIL parity_07: got %b want 1", p); end
    total++; if (len != 44) begin bad++; $display("FAIL parity_len: got %0d want 44", len); end
    total++; if (d !== 8'h07 || sb !== 1'b1) begin bad++; $display("FAIL parity_07_data: got %h stop=%b want 07/1", d, sb); end
    $display("test_parity: byte=%h parity=%b len=%0d", d, p, len);
    push(8'h03);
    get_frame(gap, d, p, len, unst, bl, sb);
    total++; if (p !== 1'b0) begin bad++; $display("FAIL parity_03: got %b want 0", p); end
    total++; if (d !== 8'h03 || unst != 0) begin bad++; $display("FAIL parity_03_data: got %h unstable=%0d want 03/0", d, unst); end
    $display("test_parity: byte=%h parity=%b len=%0d", d, p, len);
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_reset_mid_frame();
    test_empty_toggle();
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity();
`endif
    total++; if (underflow != 0) begin bad++; $display("FAIL underflow: got %0d want 0", underflow); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Drain stage directly downstream of the 16x8 byte FIFO. Pops one byte at a time through the FIFO's rd_en/data_out/empty interface and serialises it onto a single UART-style 8N1 line, LSB first, at a fixed clocks-per-bit rate. Supplies the FIFO's read side; the FIFO write side stays with the upstream producer.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..65535
DATA_W, 8, byte width; must match FIFO data width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
fifo_empty  input  1  FIFO empty flag (registered in FIFO)
fifo_data  input  DATA_W  FIFO data_out; valid the cycle after a rd_en pulse
fifo_rd_en  output  1  FIFO read strobe, registered, exactly one cycle per byte
tx  output  1  serial line, idle high, registered
tx_busy  output  1  high in every state except IDLE, registered
tx_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (reset=0, async): state=IDLE, tx=1, fifo_rd_en=0, tx_busy=0, tx_done=0, bit/baud counters=0, shift register=0.
- States: IDLE, POP, LOAD, START, DATA, STOP (PARITY when compiled in).
- IDLE: if fifo_empty=0, drive fifo_rd_en=1 next cycle and go to POP. Otherwise stay; tx=1.
- POP: fifo_rd_en=1 for this one cycle only. The FIFO updates data_out on this edge. Go to LOAD; fifo_rd_en returns to 0.
- LOAD: capture fifo_data into the shift register. Drive tx=0. Clear the baud counter. Go to START.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with tx=shift[0].
- DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit DATA_W-1 completes, go to STOP (or PARITY); tx=1.
- STOP: hold tx=1 for CLKS_PER_BIT cycles. tx_done=1 on the final cycle. Then go to IDLE.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop cycle inclusive.
- Back-to-back frames: the IDLE->POP->LOAD path leaves exactly 3 idle-high cycles between the last stop-bit cycle and the next start bit.
- Counters: baud counter sized by ceiling log2 of CLKS_PER_BIT and wraps at CLKS_PER_BIT-1. Bit index is 0..DATA_W-1. No arithmetic overflow is allowed.
- Empty is sampled only in IDLE. At most one pop is issued per frame, so the FIFO can never underflow. fifo_empty changes outside IDLE are ignored.
- fifo_rd_en is never asserted while fifo_empty=1 was sampled in IDLE.
- Reset mid-frame: tx goes high immediately and the in-flight byte is discarded (not re-read). If reset hits during POP, the FIFO's read pointer may already have advanced; that byte is lost by design.
- tx_busy=1 from POP through STOP inclusive.

Optional Feature:
Macro FIFO_UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - Holds tx = even parity (XOR of all data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes (DATA_W+3)*CLKS_PER_BIT.
- Undefined:
  - No PARITY state; DATA goes straight to STOP.
  - No parity logic is synthesised.

Test Plan:
- Reset with fifo_empty=1 for 50 cycles -> tx=1, fifo_rd_en never asserted, tx_busy=0, tx_done=0.
- CLKS_PER_BIT=4, one byte 0xA5 present -> single fifo_rd_en pulse; tx=0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles; tx_done on cycle 40 of the frame; return to IDLE.
- Three bytes 0x00, 0xFF, 0x3C queued back-to-back -> exactly 3 fifo_rd_en pulses; 3 idle-high cycles between frames; serial bytes decoded in order.
- Assert reset during DATA bit 3 of 0x55 with 2 bytes queued -> tx=1 asynchronously, state IDLE; after release, the next FIFO byte is sent and 0x55 is not retransmitted.
- fifo_empty toggled 1->0->1 while in DATA -> no extra fifo_rd_en; frame timing unchanged.
- FIFO_UART_TX_PARITY_EN defined, byte 0x07 -> parity bit=1, frame 44 cycles; byte 0x03 -> parity bit=0.
